lfsr_mask_gen: RTL and testbench



---
 rtl/mask_pkg.sv | 31 +++
 rtl/lfsr32_core.sv | 42 ++++
 rtl/lfsr_mask_gen.sv | 115 +++++++++++
 tb/tb_lfsr_mask_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mask_pkg.sv
// Shared definitions for the LFSR mask generator: feedback polynomial, FSM
// state encoding and the Galois step functions (also used as a reference model).
package mask_pkg;

    localparam logic [31:0] POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ POLY;
        end
        return n;
    endfunction

    function automatic logic [31:0] lfsr_step32(input logic [31:0] s);
        logic [31:0] n;
        n = s;
        for (int i = 0; i < 32; i++) begin
            n = lfsr_step(n);
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr32_core.sv
// 32-bit Galois LFSR state register with seed mux; advances 32 single steps
// per enabled cycle. A seed load takes priority over a step.
module lfsr32_core
    import mask_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] lfsr
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [31:0] seed_sel;

    // An all-zero state would lock the LFSR, so zero seeds fall back to SEED.
    assign seed_sel = (seed == 32'd0) ? SEED : seed;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed_sel;
        end else if (step) begin
            lfsr_d = lfsr_step32(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/lfsr_mask_gen.sv
// Pseudo-random 32-bit mask source with warm-up after every seed and a reseed
// request after RESEED_PERIOD issued masks. Define MASK_GEN_STRICT_RESEED_EN to
// stop issuing (HOLD) once the period is reached until a new seed arrives.
module lfsr_mask_gen
    import mask_pkg::*;
#(
    parameter logic [31:0] SEED          = 32'hACE1_2468,
    parameter int          WARMUP        = 4,
    parameter int          RESEED_PERIOD = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        seed_valid_i,
    input  logic [31:0] seed_i,
    output logic        mask_valid_o,
    input  logic        mask_ready_i,
    output logic [31:0] mask_o,
    output logic        reseed_req_o,
    output logic        busy_o
);

    localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);
    localparam logic [15:0] PERIOD    = 16'(RESEED_PERIOD);

    state_t      state;
    state_t      state_next;
    logic [7:0]  warm_cnt;
    logic [15:0] issue_cnt;
    logic        handshake;
    logic        lfsr_step_en;

    assign handshake    = mask_valid_o & mask_ready_i;
    assign lfsr_step_en = (state == WARM) | handshake;

    lfsr32_core #(
        .SEED (SEED)
    ) u_core (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (seed_valid_i),
        .seed (seed_i),
        .step (lfsr_step_en),
        .lfsr (mask_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= WARM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WARM: begin
                if (warm_cnt == WARM_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
`ifdef MASK_GEN_STRICT_RESEED_EN
                if ((issue_cnt == PERIOD) ||
                    (handshake && (issue_cnt == PERIOD - 16'd1))) begin
                    state_next = HOLD;
                end
`else
                state_next = RUN;
`endif
            end
            HOLD: begin
                state_next = HOLD;
            end
            default: begin
                state_next = WARM;
            end
        endcase
        // A seed load overrides everything, including a same-cycle handshake.
        if (seed_valid_i) begin
            state_next = WARM;
        end
    end

    always_comb begin
        mask_valid_o = 1'b0;
        busy_o       = 1'b0;
        reseed_req_o = (issue_cnt == PERIOD);
        case (state)
            WARM:    busy_o       = 1'b1;
            RUN:     mask_valid_o = 1'b1;
            HOLD:    mask_valid_o = 1'b0;
            default: busy_o       = 1'b1;
        endcase
    end

    // The issue count saturates so the reseed request stays latched until a seed load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            warm_cnt  <= 8'd0;
            issue_cnt <= 16'd0;
        end else if (seed_valid_i) begin
            warm_cnt  <= 8'd0;
            issue_cnt <= 16'd0;
        end else begin
            if (state == WARM) begin
                warm_cnt <= warm_cnt + 8'd1;
            end
            if (handshake && (issue_cnt != PERIOD)) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_mask_gen.sv
// Scoreboard bench for lfsr_mask_gen (WARMUP=4, RESEED_PERIOD=4); expected masks
// are queued by the stimulus and consumed by a monitor on every handshake.
module tb_lfsr_mask_gen;

    localparam logic [31:0] SEED_T   = 32'hACE1_2468;
    localparam int          WARMUP_T = 4;

    logic        clk;
    logic        rst_i;
    logic        seed_valid_i;
    logic [31:0] seed_i;
    logic        mask_valid_o;
    logic        mask_ready_i;
    logic [31:0] mask_o;
    logic        reseed_req_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    lfsr_mask_gen #(
        .SEED          (SEED_T),
        .WARMUP        (WARMUP_T),
        .RESEED_PERIOD (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .seed_valid_i (seed_valid_i),
        .seed_i       (seed_i),
        .mask_valid_o (mask_valid_o),
        .mask_ready_i (mask_ready_i),
        .mask_o       (mask_o),
        .reseed_req_o (reseed_req_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_step32(input logic [31:0] s);
        logic [31:0] n;
        n = s;
        for (int i = 0; i < 32; i++) begin
            n = (n >> 1) ^ ({32{n[0]}} & 32'h8020_0003);
        end
        return n;
    endfunction

    function automatic logic [31:0] ref_adv(input logic [31:0] s, input int k);
        logic [31:0] n;
        n = s;
        for (int i = 0; i < k; i++) begin
            n = ref_step32(n);
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!mask_valid_o && n < 20) begin
            tick();
            n++;
        end
        check(name, n, WARMUP_T);
    endtask

    task automatic issue(input int n);
        mask_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("run_valid", {31'd0, mask_valid_o}, 32'd1);
            tick();
        end
        mask_ready_i = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_i       = s;
        seed_valid_i = 1'b1;
        tick();
        seed_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_i && mask_valid_o && mask_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mask_unexpected: got %h expected none", mask_o);
            end else begin
                check("mask_stream", mask_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s4;
        logic [31:0] held;

        rst_i        = 1'b1;
        seed_valid_i = 1'b0;
        seed_i       = 32'd0;
        mask_ready_i = 1'b0;
        s4           = ref_adv(SEED_T, 4);

        check("pkg_step_1", mask_pkg::lfsr_step(32'h1), 32'h8020_0003);
        check("pkg_step_2", mask_pkg::lfsr_step(32'h2), 32'h0000_0001);
        check("pkg_step32", mask_pkg::lfsr_step32(32'h1357_9BDF), ref_step32(32'h1357_9BDF));

        // Reset values
        tick();
        tick();
        check("rst_valid", {31'd0, mask_valid_o}, 32'd0);
        check("rst_req",   {31'd0, reseed_req_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o},       32'd1);
        check("rst_mask",  mask_o,                SEED_T);

        // Warm-up after reset, then a continuous stream up to the reseed period
        mask_ready_i = 1'b1;
        rst_i        = 1'b0;
        wait_valid("warm_after_rst");
        check("first_mask", mask_o, s4);
        check("run_busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ref_adv(SEED_T, 4 + i));
        end
        issue(4);
        check("req_after_4", {31'd0, reseed_req_o}, 32'd1);
`ifdef MASK_GEN_STRICT_RESEED_EN
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", {31'd0, mask_valid_o}, 32'd0);
            check("hold_busy",  {31'd0, busy_o},       32'd0);
            check("hold_req",   {31'd0, reseed_req_o}, 32'd1);
            check("hold_mask",  mask_o,                ref_adv(SEED_T, 8));
            tick();
        end
`else
        check("adv_valid", {31'd0, mask_valid_o}, 32'd1);
        exp_q.push_back(ref_adv(SEED_T, 8));
        issue(1);
        check("adv_req", {31'd0, reseed_req_o}, 32'd1);
`endif

        // Fresh seed
        load_seed(32'h1234_5678);
        check("seed_req",   {31'd0, reseed_req_o}, 32'd0);
        check("seed_busy",  {31'd0, busy_o},       32'd1);
        check("seed_valid", {31'd0, mask_valid_o}, 32'd0);
        wait_valid("warm_after_seed");
        held = ref_adv(32'h1234_5678, 4);
        check("seed_mask", mask_o, held);

        // Backpressure: mask stable, count untouched
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_mask",  mask_o, held);
            check("bp_valid", {31'd0, mask_valid_o}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ref_adv(held, i));
        end
        issue(3);
        check("req_after_3", {31'd0, reseed_req_o}, 32'd0);

        // Seed load coincident with the 4th handshake
        exp_q.push_back(ref_adv(held, 3));
        mask_ready_i = 1'b1;
        load_seed(32'hCAFE_F00D);
        mask_ready_i = 1'b0;
        check("coinc_req",   {31'd0, reseed_req_o}, 32'd0);
        check("coinc_valid", {31'd0, mask_valid_o}, 32'd0);
        wait_valid("warm_after_coinc");
        check("coinc_mask", mask_o, ref_adv(32'hCAFE_F00D, 4));
        exp_q.push_back(ref_adv(32'hCAFE_F00D, 4));
        issue(1);

        // Zero seed substitution
        load_seed(32'h0000_0000);
        check("zero_valid", {31'd0, mask_valid_o}, 32'd0);
        wait_valid("warm_after_zero");
        check("zero_mask", mask_o, s4);
        exp_q.push_back(s4);
        issue(1);

        // Reset during the second warm-up cycle
        load_seed(32'h0BAD_BEEF);
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_mask",  mask_o,                SEED_T);
        check("arst_busy",  {31'd0, busy_o},       32'd1);
        check("arst_valid", {31'd0, mask_valid_o}, 32'd0);
        check("arst_req",   {31'd0, reseed_req_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        wait_valid("warm_after_arst");
        check("arst_first_mask", mask_o, s4);
        exp_q.push_back(s4);
        issue(1);

        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
